// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the javk multi-cycle controller: states, opcodes,
// ALU codes and the decode class bundle.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_NONE = 3'd0;

  typedef struct packed {
    logic is_alu;
    logic is_ldi;
    logic is_ld;
    logic is_st;
    logic is_mem;
    logic is_jmp;
    logic is_jz;
    logic is_hlt;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_seq_dec.sv
// Combinational opcode classifier. Opcode bits above bit 3 must be zero,
// otherwise the instruction is illegal.
module ctrl_seq_dec
  import ctrl_seq_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output dec_t           dec
);

  logic [3:0] op4;
  logic       hi;

  assign op4 = opcode[3:0];
  assign hi  = |(opcode >> 4);

  always_comb begin
    dec = '0;
    if (hi) begin
      dec.illegal = 1'b1;
    end else begin
      case (op4)
        OP_NOP: ;
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: dec.is_alu = 1'b1;
        OP_LDI: dec.is_ldi = 1'b1;
        OP_LD: begin
          dec.is_ld  = 1'b1;
          dec.is_mem = 1'b1;
        end
        OP_ST: begin
          dec.is_st  = 1'b1;
          dec.is_mem = 1'b1;
        end
        OP_JMP: dec.is_jmp = 1'b1;
        OP_JZ:  dec.is_jz  = 1'b1;
        OP_HLT: dec.is_hlt = 1'b1;
        default: dec.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// javk multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB/HALT with bounded memory waits.
// Define ILLEGAL_TRAP_EN to halt with err on illegal opcodes; otherwise they run as NOP.
module ctrl_seq
  import ctrl_seq_pkg::*;
#(
  parameter int IW       = 8,
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IW-1:0]     instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              zero,
  input  logic              mem_ack,
  output logic [OPW-1:0]    opcode,
  output logic [IW-OPW-1:0] operand,
  output logic [2:0]        alu_op,
  output logic              alu_en,
  output logic              reg_we,
  output logic              imm_sel,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              halted,
  output logic              err
);

  localparam int            CW       = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  dec_t          dec;

  ctrl_seq_dec #(.OPW(OPW)) u_dec (
    .opcode (ir_q[IW-1 -: OPW]),
    .dec    (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cnt_d = '0;
        if (dec.is_mem) begin
          state_d = S_MEM;
        end else if (dec.is_hlt) begin
          state_d = S_HALT;
        end else if (dec.illegal) begin
`ifdef ILLEGAL_TRAP_EN
          err_d   = 1'b1;
          state_d = S_HALT;
`else
          state_d = S_EXEC;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_FETCH;
      S_MEM: begin
        // ack wins over timeout on the last allowed cycle
        if (mem_ack) begin
          state_d = dec.is_ld ? S_WB : S_FETCH;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB:   state_d = S_FETCH;
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  assign opcode  = ir_q[IW-1 -: OPW];
  assign operand = ir_q[IW-OPW-1:0];
  assign err     = err_q;

  always_comb begin
    instr_ready = 1'b0;
    pc_inc      = 1'b0;
    alu_op      = dec.is_alu ? opcode[2:0] : ALU_NONE;
    alu_en      = 1'b0;
    reg_we      = 1'b0;
    imm_sel     = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        pc_inc      = instr_valid;
      end
      S_EXEC: begin
        alu_en  = dec.is_alu;
        reg_we  = dec.is_alu | dec.is_ldi;
        imm_sel = dec.is_ldi;
        pc_load = dec.is_jmp | (dec.is_jz & zero);
      end
      S_MEM: begin
        mem_rd = dec.is_ld;
        mem_wr = dec.is_st;
      end
      S_WB:   reg_we = 1'b1;
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: transaction-timeline model compared every cycle,
// plus literal expectations at the key points of each instruction.
module tb_ctrl_seq;

  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       instr_ready, alu_en, reg_we, imm_sel, mem_rd, mem_wr;
  logic       pc_inc, pc_load, halted, err;
  logic [3:0] opcode, operand;
  logic [2:0] alu_op;

  int errors = 0;
  int checks = 0;

  ctrl_seq #(.IW(8), .OPW(4), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .zero(zero), .mem_ack(mem_ack),
    .opcode(opcode), .operand(operand), .alu_op(alu_op), .alu_en(alu_en),
    .reg_we(reg_we), .imm_sel(imm_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // Timeline model: outputs depend on cycles elapsed since the handshake.
  int         cyc = 0;
  int         t_hs = 0;
  int         ack_at = -1;
  logic       armed = 1'b0;
  logic       busy_m = 1'b0;
  logic       halt_m = 1'b0;
  logic       err_m = 1'b0;
  logic [7:0] ir_m = 8'h00;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == 4'h9) || (op == 4'hA);
  endfunction

  function automatic logic [21:0] model_out();
    logic rdy, pci, aen, rwe, isel, mrd, mwr, pld, hlt;
    logic [2:0] aop;
    logic [3:0] op;
    int d, w;
    {rdy, pci, aen, rwe, isel, mrd, mwr, pld, hlt} = '0;
    op  = ir_m[7:4];
    d   = cyc - t_hs;
    w   = d - 2;
    aop = (op >= 4'h1 && op <= 4'h7) ? op[2:0] : 3'd0;
    if (halt_m) begin
      hlt = 1'b1;
    end else if (!busy_m) begin
      rdy = 1'b1;
      pci = instr_valid;
    end else if (is_mem_op(op)) begin
      if (ack_at < 0 && d >= 2) begin
        mrd = (op == 4'h9);
        mwr = (op == 4'hA);
      end else if (ack_at >= 0 && op == 4'h9 && w == ack_at + 1) begin
        rwe = 1'b1;
      end
    end else if (d == 2) begin
      if (aop != 3'd0) begin aen = 1'b1; rwe = 1'b1; end
      if (op == 4'h8) begin rwe = 1'b1; isel = 1'b1; end
      if (op == 4'hB) pld = 1'b1;
      if (op == 4'hC) pld = zero;
    end
    return {rdy, pci, ir_m[7:4], ir_m[3:0], aop, aen, rwe, isel, mrd, mwr, pld, hlt, err_m};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      armed  <= 1'b1;
      busy_m <= 1'b0;
      halt_m <= 1'b0;
      err_m  <= 1'b0;
      ir_m   <= 8'h00;
    end else if (halt_m) begin
    end else if (!busy_m) begin
      if (instr_valid) begin
        busy_m <= 1'b1;
        t_hs   <= cyc;
        ir_m   <= instr;
        ack_at <= -1;
      end
    end else if (is_mem_op(ir_m[7:4])) begin
      if (cyc - t_hs >= 2) begin
        if (ack_at < 0) begin
          if (mem_ack) begin
            ack_at <= cyc - t_hs - 2;
            if (ir_m[7:4] == 4'hA) busy_m <= 1'b0;
          end else if (cyc - t_hs - 2 == WAIT_MAX - 1) begin
            halt_m <= 1'b1;
            err_m  <= 1'b1;
            busy_m <= 1'b0;
          end
        end else begin
          busy_m <= 1'b0;
        end
      end
    end else if (cyc - t_hs == 1) begin
      if (ir_m[7:4] == 4'hF) begin
        halt_m <= 1'b1;
        busy_m <= 1'b0;
      end
`ifdef ILLEGAL_TRAP_EN
      else if (ir_m[7:4] == 4'hD || ir_m[7:4] == 4'hE) begin
        halt_m <= 1'b1;
        err_m  <= 1'b1;
        busy_m <= 1'b0;
      end
`endif
    end else begin
      busy_m <= 1'b0;
    end
  end

  wire [21:0] dut_vec = {instr_ready, pc_inc, opcode, operand, alu_op, alu_en,
                         reg_we, imm_sel, mem_rd, mem_wr, pc_load, halted, err};

  always @(negedge clk) begin
    logic [21:0] exp_v;
    if (armed) begin
      exp_v = model_out();
      checks++;
      if (dut_vec !== exp_v) begin
        errors++;
        $display("FAIL cycle_cmp cyc=%0d got=%06h exp=%06h", cyc, dut_vec, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] w);
    step();
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("pc_inc_hs", pc_inc, 1);
    chk("ready_hs", instr_ready, 1);
    step();
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    step();
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_halted", halted, 0);
    chk("rst_opcode", opcode, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", instr_ready, 1);
    chk("reset_strobes", {alu_en, reg_we, mem_rd, mem_wr, pc_inc, pc_load, halted, err}, 0);

    // ADD 0x13
    send(8'h13);
    @(negedge clk);
    chk("add_decode_alu_en", alu_en, 0);
    step();
    @(negedge clk);
    chk("add_alu_op", alu_op, 3'd1);
    chk("add_alu_en", alu_en, 1);
    chk("add_reg_we", reg_we, 1);
    step();
    @(negedge clk);
    chk("add_ready_back", instr_ready, 1);
    chk("add_alu_en_off", alu_en, 0);

    // LDI 0x85, with valid held in DECODE (must be ignored)
    send(8'h85);
    instr       = 8'h13;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("ldi_dec_ready", instr_ready, 0);
    chk("ldi_dec_pc_inc", pc_inc, 0);
    step();
    instr_valid = 1'b0;
    @(negedge clk);
    chk("ldi_reg_we", reg_we, 1);
    chk("ldi_imm_sel", imm_sel, 1);
    chk("ldi_operand", operand, 4'h5);
    step();
    @(negedge clk);
    chk("ldi_ready_back", instr_ready, 1);

    // LD 0x92, ack on third MEM cycle
    send(8'h92);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) mem_ack = 1'b1;
      @(negedge clk);
      chk("ld_mem_rd", mem_rd, 1);
    end
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("ld_wb_rd_off", mem_rd, 0);
    chk("ld_wb_reg_we", reg_we, 1);
    chk("ld_wb_imm_sel", imm_sel, 0);
    step();
    @(negedge clk);
    chk("ld_ready_back", instr_ready, 1);

    // ST with ack on first MEM cycle
    send(8'hA1);
    step();
    mem_ack = 1'b1;
    @(negedge clk);
    chk("st_fast_wr", mem_wr, 1);
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("st_fast_wr_off", mem_wr, 0);
    chk("st_fast_ready", instr_ready, 1);

    // JZ taken then not taken, then JMP
    zero = 1'b1;
    send(8'hC7);
    step();
    @(negedge clk);
    chk("jz_taken", pc_load, 1);
    step();
    zero = 1'b0;
    send(8'hC7);
    step();
    @(negedge clk);
    chk("jz_not_taken", pc_load, 0);
    send(8'hB3);
    step();
    @(negedge clk);
    chk("jmp_load", pc_load, 1);
    chk("jmp_operand", operand, 4'h3);

    // illegal opcode 0xD0
    send(8'hD0);
    step();
    @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
    chk("ill_err", err, 1);
    chk("ill_halted", halted, 1);
    do_reset();
`else
    chk("ill_nop_strobes", {alu_en, reg_we, pc_load, mem_rd, mem_wr}, 0);
    chk("ill_nop_err", err, 0);
    step();
    @(negedge clk);
    chk("ill_nop_ready", instr_ready, 1);
`endif

    // reset in the middle of a load
    send(8'h92);
    step();
    @(negedge clk);
    chk("rstmem_rd", mem_rd, 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmem_rd_off", mem_rd, 0);
    chk("rstmem_no_wb", reg_we, 0);
    chk("rstmem_ready", instr_ready, 1);

    // HLT
    send(8'hF0);
    step();
    @(negedge clk);
    chk("hlt_halted", halted, 1);
    chk("hlt_err", err, 0);
    do_reset();

    // ST with no ack: timeout
    send(8'hA1);
    for (int i = 0; i < WAIT_MAX; i++) begin
      step();
      @(negedge clk);
      chk("st_to_wr", mem_wr, 1);
    end
    step();
    @(negedge clk);
    chk("st_to_wr_off", mem_wr, 0);
    chk("st_to_err", err, 1);
    chk("st_to_halted", halted, 1);
    chk("st_to_ready", instr_ready, 0);
    step();
    instr       = 8'h13;
    instr_valid = 1'b1;
    @(negedge clk);
    chk("halt_ignore_ready", instr_ready, 0);
    chk("halt_ignore_pc_inc", pc_inc, 0);
    step();
    instr_valid = 1'b0;
    do_reset();

    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
